// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-FF sync, polarity select, tick-based
// debounce, press/release pulses and optional hold-to-repeat, one shared 1 ms prescaler.
module btn_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int TICK_CYCLES     = 50000,
  parameter int STABLE_MS       = 40,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_btn,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_repeat,
  output logic              o_tick
);

  localparam int                TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]     TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam int                DW          = $clog2(STABLE_MS + 1);
  localparam logic [DW-1:0]     STABLE_LAST = DW'(STABLE_MS - 1);
  localparam logic [NUM_CH-1:0] REL_LEVEL   = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RATE  = 2'd2
  } rep_state_e;

  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              tick_s;
  logic [NUM_CH-1:0] sync_meta_q, sync_q, pressed_raw_s;

  assign tick_s = (tcnt_q == TICK_LAST);
  assign o_tick = tick_s;

  always_comb begin
    tcnt_d = tcnt_q;
    if (tick_s) tcnt_d = '0;
    else        tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end

  // Synchroniser resets to the released pin value so a held key after reset is a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta_q <= REL_LEVEL;
      sync_q      <= REL_LEVEL;
    end else begin
      sync_meta_q <= i_btn;
      sync_q      <= sync_meta_q;
    end
  end

  assign pressed_raw_s = sync_q ^ REL_LEVEL;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          flip_s;

    assign flip_s = (pressed_raw_s[ch] != level_q) && tick_s && (dcnt_q == STABLE_LAST);

    always_comb begin
      dcnt_d    = dcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (pressed_raw_s[ch] == level_q) begin
        dcnt_d = '0;
      end else if (flip_s) begin
        level_d   = ~level_q;
        dcnt_d    = '0;
        press_d   = ~level_q;
        release_d = level_q;
      end else if (tick_s) begin
        dcnt_d = dcnt_q + DW'(1);
      end else begin
        dcnt_d = dcnt_q;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        dcnt_q    <= dcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign o_level[ch]   = level_q;
    assign o_press[ch]   = press_q;
    assign o_release[ch] = release_q;

    if (REPEAT_EN != 0) begin : g_rep
      localparam int            RMAX       = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
      localparam int            HW         = $clog2(RMAX + 1);
      localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_MS - 1);
      localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_MS - 1);

      rep_state_e    state_q, state_d;
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          repeat_q, repeat_d;
      logic          press_ev_s, release_ev_s;

      // Events are taken from the debounce flip itself so DELAY starts the same edge o_press rises.
      assign press_ev_s   = flip_s & ~level_q;
      assign release_ev_s = flip_s & level_q;

      always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        repeat_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            hcnt_d = '0;
            if (press_ev_s) state_d = ST_DELAY;
            else            state_d = ST_IDLE;
          end
          ST_DELAY: begin
            if (release_ev_s) begin
              state_d = ST_IDLE;
              hcnt_d  = '0;
            end else if (tick_s && (hcnt_q == DELAY_LAST)) begin
              repeat_d = 1'b1;
              hcnt_d   = '0;
              state_d  = ST_RATE;
            end else if (tick_s) begin
              hcnt_d = hcnt_q + HW'(1);
            end else begin
              hcnt_d = hcnt_q;
            end
          end
          ST_RATE: begin
            if (release_ev_s) begin
              state_d = ST_IDLE;
              hcnt_d  = '0;
            end else if (tick_s && (hcnt_q == RATE_LAST)) begin
              repeat_d = 1'b1;
              hcnt_d   = '0;
            end else if (tick_s) begin
              hcnt_d = hcnt_q + HW'(1);
            end else begin
              hcnt_d = hcnt_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end
        endcase
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state_q  <= ST_IDLE;
          hcnt_q   <= '0;
          repeat_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          hcnt_q   <= hcnt_d;
          repeat_q <= repeat_d;
        end
      end

      assign o_repeat[ch] = repeat_q;
    end else begin : g_norep
      assign o_repeat[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short tick: debounce latency, bounce,
// repeat timing, multi-channel, mid-run reset and parameter variants.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn, level, press, rel, rep;
  logic       tick;
  logic [3:0] btn_ah, level_ah, press_ah, rel_ah, rep_ah;
  logic       tick_ah;
  logic [3:0] btn_nr, level_nr, press_nr, rel_nr, rep_nr;
  logic       tick_nr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.NUM_CH(4), .TICK_CYCLES(4), .STABLE_MS(3), .ACTIVE_LOW(1), .REPEAT_EN(1),
                    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .o_level(level), .o_press(press),
    .o_release(rel), .o_repeat(rep), .o_tick(tick));

  btn_conditioner #(.NUM_CH(4), .TICK_CYCLES(4), .STABLE_MS(3), .ACTIVE_LOW(0), .REPEAT_EN(1),
                    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)) dut_ah (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_ah), .o_level(level_ah), .o_press(press_ah),
    .o_release(rel_ah), .o_repeat(rep_ah), .o_tick(tick_ah));

  btn_conditioner #(.NUM_CH(4), .TICK_CYCLES(4), .STABLE_MS(3), .ACTIVE_LOW(1), .REPEAT_EN(0),
                    .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)) dut_nr (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_nr), .o_level(level_nr), .o_press(press_nr),
    .o_release(rel_nr), .o_repeat(rep_nr), .o_tick(tick_nr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for level[ch] to reach val; capture pulses seen in that cycle.
  task automatic wait_level(input int ch, input logic val, output int lat,
                            output logic [3:0] pr, output logic [3:0] rl, output logic [3:0] rp);
    lat = -1; pr = 4'h0; rl = 4'h0; rp = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (level[ch] === val) begin
        lat = k; pr = press; rl = rel; rp = rep;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int lat, bad, nrep, nrel, t;
    logic [3:0] pr, rl, rp;
    logic relseen;

    rst_n = 1'b0; btn = 4'hF; btn_ah = 4'h0; btn_nr = 4'hF;
    step(3);
    chk("reset_outputs", {15'd0, level, press, rel, rep, tick}, 32'd0);
    chk("reset_variants", {level_ah, press_ah, rel_ah, rep_ah, level_nr, press_nr, rel_nr, rep_nr},
        32'd0);
    rst_n = 1'b1;
    step(2);

    // clean press / release on channel 0
    btn[0] = 1'b0;
    wait_level(0, 1'b1, lat, pr, rl, rp);
    chk_range("press0_latency", lat, 11, 14);
    chk("press0_pulse", {28'd0, pr}, 32'h1);
    step(1);
    chk("press0_single", {28'd0, press}, 32'h0);
    chk("press0_level_held", {28'd0, level}, 32'h1);
    btn[0] = 1'b1;
    wait_level(0, 1'b0, lat, pr, rl, rp);
    chk_range("release0_latency", lat, 11, 14);
    chk("release0_pulse", {28'd0, rl}, 32'h1);
    step(1);
    chk("release0_single", {28'd0, rel}, 32'h0);

    // bounce on channel 1
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 6 == 0) btn[1] = ~btn[1];
      @(negedge clk);
      if (level[1] !== 1'b0 || press[1] !== 1'b0 || rel[1] !== 1'b0) bad++;
    end
    chk("bounce_quiet", bad, 0);
    btn[1] = 1'b0;
    wait_level(1, 1'b1, lat, pr, rl, rp);
    chk_range("bounce_press_latency", lat, 11, 14);
    chk("bounce_press_pulse", {28'd0, pr}, 32'h2);
    btn[1] = 1'b1;
    wait_level(1, 1'b0, lat, pr, rl, rp);
    chk("bounce_release_pulse", {28'd0, rl}, 32'h2);

    // auto-repeat on channel 2: first at +20, then every 8
    btn[2] = 1'b0;
    wait_level(2, 1'b1, lat, pr, rl, rp);
    chk("rep_press_pulse", {28'd0, pr}, 32'h4);
    chk("rep_not_with_press", {28'd0, rp}, 32'h0);
    bad = 0; nrep = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (rep[2] !== ((k >= 20 && (k - 20) % 8 == 0) ? 1'b1 : 1'b0)) bad++;
      if (rep[2] === 1'b1) nrep++;
    end
    chk("rep_timing_errs", bad, 0);
    chk("rep_count", nrep, 8);
    btn[2] = 1'b1;
    wait_level(2, 1'b0, lat, pr, rl, rp);
    chk("rep_release_pulse", {28'd0, rl}, 32'h4);
    chk("rep_none_at_release", {31'd0, rp[2]}, 32'h0);
    nrep = 0; nrel = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rep[2] === 1'b1) nrep++;
      if (rel[2] === 1'b1) nrel++;
    end
    chk("rep_after_release", nrep, 0);
    chk("release_after_release", nrel, 0);

    // simultaneous channels
    btn = 4'b0000;
    wait_level(0, 1'b1, lat, pr, rl, rp);
    chk("simul_press", {28'd0, pr}, 32'hF);
    chk("simul_level", {28'd0, level}, 32'hF);
    btn = 4'b1100;
    wait_level(2, 1'b0, lat, pr, rl, rp);
    chk("simul_release", {28'd0, rl}, 32'hC);
    chk("simul_level_after", {28'd0, level}, 32'h3);
    chk("simul_no_press", {28'd0, pr}, 32'h0);

    // mid-repeat reset with channels 0/1 held
    step(15);
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", {15'd0, level, press, rel, rep, tick}, 32'd0);
    step(2);
    rst_n = 1'b1;
    lat = -1; relseen = 1'b0; pr = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (|rel) relseen = 1'b1;
      if (level[0] === 1'b1) begin
        lat = k; pr = press;
        break;
      end
    end
    chk_range("midreset_press_latency", lat, 11, 14);
    chk("midreset_press_pulse", {28'd0, pr}, 32'h3);
    chk("midreset_no_release", {31'd0, relseen}, 32'h0);

    // ACTIVE_LOW=0 variant: high input means pressed
    btn_ah[0] = 1'b1;
    lat = -1; pr = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (level_ah[0] === 1'b1) begin
        lat = k; pr = press_ah;
        break;
      end
    end
    chk_range("ah_press_latency", lat, 11, 14);
    chk("ah_press_pulse", {28'd0, pr}, 32'h1);

    // REPEAT_EN=0 variant held 100 cycles
    btn_nr[0] = 1'b0;
    nrep = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rep_nr !== 4'h0) nrep++;
    end
    chk("norep_level", {28'd0, level_nr}, 32'h1);
    chk("norep_no_repeat", nrep, 0);

    // tick period and width
    t = -1;
    for (int k = 0; k < 10; k++) begin
      if (tick === 1'b1) break;
      @(negedge clk);
    end
    step(1);
    chk("tick_width", {31'd0, tick}, 32'h0);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        t = k;
        break;
      end
    end
    chk("tick_period", t, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel push-button conditioner. Successor to the single-channel per-key debouncer.
- Per channel, in one block: 2-FF synchronisation, selectable input polarity, debounce against a shared millisecond tick, press/release edge pulses, and optional hold-to-repeat pulses.
- Sits between board KEY/SW pins and the CPU button I/O register.
- All channels share one tick prescaler, replacing N independent cycle counters.

Parameters:
- NUM_CH, 4, number of independent channels.
- TICK_CYCLES, 50000, clock cycles per 1 ms tick (50 MHz default); benches override to a small value.
- STABLE_MS, 40, ticks an input must stay changed before the debounced level flips; range 1..1023.
- ACTIVE_LOW, 1, 1: raw input low = pressed; 0: raw high = pressed.
- REPEAT_EN, 1, 1: generate repeat pulses while held; 0: o_repeat tied 0.
- REPEAT_DELAY_MS, 500, ticks from press to first repeat pulse; must be ≥ 1.
- REPEAT_RATE_MS, 100, ticks between subsequent repeat pulses; must be ≥ 1.

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_btn, in, NUM_CH, raw asynchronous button inputs.
- o_level, out, NUM_CH, debounced level; 1 = pressed, independent of ACTIVE_LOW.
- o_press, out, NUM_CH, one-cycle pulse on debounced 0→1.
- o_release, out, NUM_CH, one-cycle pulse on debounced 1→0.
- o_repeat, out, NUM_CH, one-cycle pulse per auto-repeat event.
- o_tick, out, 1, shared 1 ms tick, one cycle wide; exported for other timers.

Behaviour:
- Reset:
  - All registers are asynchronously cleared; all outputs are 0.
  - Synchroniser FFs reset to the released value: ACTIVE_LOW, so inputs read "released".
  - Tick counter resets to 0.
- Tick prescaler:
  - Free-running 0..TICK_CYCLES-1.
  - o_tick = 1 in the cycle the count equals TICK_CYCLES-1; the count then wraps to 0.
- Synchroniser:
  - 2 FFs per channel.
  - pressed_raw = sync_out XOR ACTIVE_LOW.
- Debounce, per channel:
  - Count register, width $clog2(STABLE_MS+1).
  - If pressed_raw == o_level: count is cleared every cycle, including any bounce back mid-count.
  - Else, on o_tick: count increments.
  - If o_tick and count == STABLE_MS-1 while mismatched: at that edge o_level toggles, count clears, and o_press or o_release asserts for exactly that one cycle.
  - Resulting latency from raw edge to o_level change: between 3+(STABLE_MS-1)*TICK_CYCLES and 2+STABLE_MS*TICK_CYCLES cycles.
- Repeat FSM, per channel, states IDLE / DELAY / RATE; hold counter width fits max(REPEAT_DELAY_MS, REPEAT_RATE_MS).
  - IDLE: enter DELAY on the press event; hold counter = 0.
  - DELAY: hold counter increments on o_tick. When o_tick and the counter equals REPEAT_DELAY_MS-1: o_repeat pulses, counter clears, go to RATE.
  - RATE: same mechanism with REPEAT_RATE_MS; o_repeat pulses on each wrap; stay in RATE.
  - Release event in any state: return to IDLE the same edge, counter cleared, no o_repeat that cycle.
  - Release and repeat due in the same cycle: release wins.
  - REPEAT_EN=0: FSM is not generated; o_repeat = 0.
- o_press never coincides with o_repeat (press enters DELAY with counter 0).
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Reset asserted mid-debounce or mid-repeat:
  - Immediately clears all state; no pulses are emitted.
  - After deassertion, a button still held is seen as a new press after full debounce.
- The block contains no combinational path from i_btn to any output.

Test Plan (TICK_CYCLES=4, STABLE_MS=3, ACTIVE_LOW=1, NUM_CH=4, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2 unless stated):
- Reset and clean press:
  - Hold i_rst_n=0 with i_btn=4'b1111 → all outputs 0.
  - Release reset, drive i_btn[0]=0 → o_level[0] rises 11..14 cycles later; o_press[0] high exactly that cycle.
  - Release i_btn[0]=1 → o_release[0] one-cycle pulse after the same latency window.
- Bounce rejection:
  - Toggle i_btn[1] low/high every 6 cycles for 60 cycles → o_level[1] stays 0, no pulses.
  - Then hold low → single o_press[1].
- Auto-repeat:
  - Hold i_btn[2] low 80 cycles after press → o_repeat[2] pulses 20 cycles after o_press[2], then every 8 cycles.
  - Release → no further o_repeat[2]; exactly one o_release[2].
- Simultaneous channels:
  - Drive i_btn[3:0]=0000 in one cycle → all four o_press bits assert in the same cycle.
  - Release two channels only → those two o_release bits only.
- Mid-operation reset:
  - Assert i_rst_n=0 mid-repeat with button held → outputs 0 asynchronously.
  - After deassert → fresh o_press after 11..14 cycles, no o_release.
- Parameter variants:
  - ACTIVE_LOW=0 with i_btn=1 → press.
  - REPEAT_EN=0 held 100 cycles → o_repeat stays 0.
  - o_tick period is exactly 4 cycles.
